// File: rtl/vga_plot_sink.sv
// vga_plot_sink: 160x120x3 framebuffer written through a plot port and scanned out as VGA,
// each stored pixel shown as a 4x4 block. Define VGA_FRAME_CLEAR_EN to zero it after reset.
module vga_plot_sink #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] color,
    input  logic       plot,
    output logic       busy,
    output logic       frame_start,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned FB_SIZE = 160 * 120;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEGIN = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEGIN = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [14:0]   FB_END   = 15'(FB_SIZE);

    logic          phase_q;
    logic          tick;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;
    logic          hs_n_d, vs_n_d, blank_n_d;

    logic          hs_q, vs_q, blank_q, fs_q;
    logic [2:0]    rgb_q;

    logic [2:0]    mem [FB_SIZE];
    logic [2:0]    rd_data_q;
    logic [14:0]   rd_row, rd_col, rd_addr;
    logic [14:0]   wr_row, wr_addr;
    logic          plot_ok;
    logic          clr_we;
    logic [14:0]   clr_addr;
    logic          mem_we;
    logic [14:0]   mem_waddr;
    logic [2:0]    mem_wdata;

    assign tick = phase_q;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (tick) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hs_n_d    = !((h_q >= HS_BEGIN) && (h_q < HS_END));
        vs_n_d    = !((v_q >= VS_BEGIN) && (v_q < VS_END));
        blank_n_d = (h_q < H_VIS) && (v_q < V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            phase_q <= ~phase_q;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // y*160 + x as shifts; read side uses the scan position divided by the 4x4 block size
    always_comb begin
        wr_row  = {7'b0, y};
        wr_addr = (wr_row << 7) + (wr_row << 5) + {7'b0, x};
        rd_row  = 15'(v_q >> 2);
        rd_col  = 15'(h_q >> 2);
        rd_addr = (rd_row << 7) + (rd_row << 5) + rd_col;
    end

`ifdef VGA_FRAME_CLEAR_EN
    logic        busy_q;
    logic [14:0] clr_addr_q;

    // One address per clk; busy drops on the clk after the last address is written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
        end else if (busy_q) begin
            if (clr_addr_q == FB_END) begin
                busy_q <= 1'b0;
            end else begin
                clr_addr_q <= clr_addr_q + 15'd1;
            end
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q && (clr_addr_q != FB_END);
    assign clr_addr = clr_addr_q;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    always_comb begin
        plot_ok   = plot && (x < 8'd160) && (y < 8'd120) && !busy;
        mem_we    = clr_we || plot_ok;
        mem_waddr = clr_we ? clr_addr : wr_addr;
        mem_wdata = clr_we ? 3'b000 : color;
    end

    // Read-before-write: a same-address collision returns the old colour
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= 3'b000;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= tick && h_wrap && v_wrap;
            if (tick) begin
                hs_q    <= hs_n_d;
                vs_q    <= vs_n_d;
                blank_q <= blank_n_d;
                rgb_q   <= blank_n_d ? rd_data_q : 3'b000;
            end
        end
    end

    assign frame_start = fs_q;
    assign vga_clk     = phase_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = {8{rgb_q[2]}};
    assign vga_g       = {8{rgb_q[1]}};
    assign vga_b       = {8{rgb_q[0]}};

endmodule
